converge_ctrl_rr: RTL and testbench

//  Parametrised converger: merges NUM_OUT_PORTS output-port packet streams and NUM_IN_PORTS freespace-update

---
 rtl/converge_ctrl_rr.sv | 228 ++++++++++++++++++++++
 tb/tb_converge_ctrl_rr.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/converge_ctrl_rr.sv
// converge_ctrl_rr: merges freespace-update packets (strict priority) and round-robin port data into one stream.
// Optional build macro CONVERGE_STATS_EN adds the pkt_count valid-beat counter.
`timescale 1ns/1ps
module converge_ctrl_rr #(
    parameter int PACKET_BITS   = 97,
    parameter int NUM_IN_PORTS  = 7,
    parameter int NUM_OUT_PORTS = 7,
    parameter int PORT_BITS     = 4,
    parameter int UPD_ASIZE     = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_IN_PORTS-1:0]          freespace_update,
    input  logic [PACKET_BITS*NUM_IN_PORTS-1:0]  packet_from_input_ports,
    input  logic [PACKET_BITS*NUM_OUT_PORTS-1:0] packet_from_output_ports,
    input  logic [NUM_OUT_PORTS-1:0]         empty,
    input  logic                             resend,
    output logic [NUM_OUT_PORTS-1:0]         outport_sel,
    output logic [PACKET_BITS-1:0]           stream_out,
    output logic                             stream_valid,
    output logic                             upd_overflow,
    output logic [31:0]                      pkt_count
);
    localparam int FIFO_DEPTH = 1 << UPD_ASIZE;

    typedef enum logic [1:0] {RUN, HOLD, REPLAY} state_t;

    logic [NUM_IN_PORTS-1:0]    fsu_q, rise;
    logic [PACKET_BITS-1:0]     slot [NUM_IN_PORTS];
    logic [PACKET_BITS-1:0]     scan_pkt;
    logic [PORT_BITS-1:0]       scan_ptr;
    logic [PACKET_BITS-1:0]     fifo_mem [FIFO_DEPTH];
    logic [UPD_ASIZE-1:0]       wr_ptr, rd_ptr;
    logic [UPD_ASIZE:0]         fifo_cnt;
    logic [PACKET_BITS-1:0]     fifo_dout;
    logic                       fifo_full, fifo_empty, drain_wr, rd_en, lose_upd;
    logic [PORT_BITS-1:0]       rr_ptr, grant_idx;
    logic [2*NUM_OUT_PORTS-1:0] rot;
    logic                       grant_vld, issue_ok;
    logic                       infl_vld, infl_fifo;
    logic [PORT_BITS-1:0]       infl_port;
    logic [PACKET_BITS-1:0]     infl_data, skid_reg, so_nxt;
    logic                       skid_vld, sv_nxt, so_load, skid_load, skid_clr;
    state_t                     state, state_nxt;

    assign rise       = freespace_update & ~fsu_q;
    assign fifo_full  = (fifo_cnt == (UPD_ASIZE+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign drain_wr   = scan_pkt[PACKET_BITS-1] && !fifo_full;
    assign issue_ok   = !reset && (state == RUN) && !resend;
    assign rd_en      = issue_ok && !fifo_empty;

    always_comb begin
        scan_pkt = '0;
        lose_upd = 1'b0;
        for (int unsigned i = 0; i < NUM_IN_PORTS; i++) begin
            if (scan_ptr == PORT_BITS'(i))
                scan_pkt = slot[i];
        end
        // a capture onto a pending slot loses the old packet unless it drains this same cycle
        for (int unsigned i = 0; i < NUM_IN_PORTS; i++) begin
            if (rise[i] && slot[i][PACKET_BITS-1] && !(drain_wr && scan_ptr == PORT_BITS'(i)))
                lose_upd = 1'b1;
        end
    end

    always_comb begin
        int unsigned sum;
        grant_vld = 1'b0;
        grant_idx = '0;
        sum       = 0;
        rot       = {~empty, ~empty} >> rr_ptr;
        for (int unsigned k = 0; k < NUM_OUT_PORTS; k++) begin
            if (!grant_vld && rot[k]) begin
                grant_vld = 1'b1;
                sum       = 32'(rr_ptr) + k;
                if (sum >= NUM_OUT_PORTS)
                    sum = sum - NUM_OUT_PORTS;
                grant_idx = PORT_BITS'(sum);
            end
        end
        if (!(issue_ok && fifo_empty))
            grant_vld = 1'b0;
    end

    always_comb begin
        outport_sel = '0;
        for (int unsigned j = 0; j < NUM_OUT_PORTS; j++)
            outport_sel[j] = grant_vld && (grant_idx == PORT_BITS'(j));
    end

    always_comb begin
        infl_data = fifo_dout;
        if (!infl_fifo) begin
            for (int unsigned j = 0; j < NUM_OUT_PORTS; j++) begin
                if (infl_port == PORT_BITS'(j))
                    infl_data = packet_from_output_ports[j*PACKET_BITS +: PACKET_BITS];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        sv_nxt    = 1'b0;
        so_load   = 1'b0;
        so_nxt    = infl_data;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        case (state)
            RUN: begin
                if (resend) begin
                    state_nxt = HOLD;
                    skid_load = 1'b1;
                end else begin
                    sv_nxt  = infl_vld;
                    so_load = infl_vld;
                end
            end
            HOLD: begin
                if (!resend)
                    state_nxt = REPLAY;
            end
            REPLAY: begin
                if (resend) begin
                    state_nxt = HOLD;
                end else begin
                    state_nxt = RUN;
                    sv_nxt    = skid_vld;
                    so_load   = skid_vld;
                    so_nxt    = skid_reg;
                    skid_clr  = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsu_q        <= '0;
            scan_ptr     <= '0;
            upd_overflow <= 1'b0;
            for (int unsigned i = 0; i < NUM_IN_PORTS; i++)
                slot[i] <= '0;
        end else begin
            fsu_q    <= freespace_update;
            scan_ptr <= (scan_ptr == PORT_BITS'(NUM_IN_PORTS-1)) ? '0 : scan_ptr + PORT_BITS'(1);
            if (lose_upd)
                upd_overflow <= 1'b1;
            for (int unsigned i = 0; i < NUM_IN_PORTS; i++) begin
                if (rise[i])
                    slot[i] <= packet_from_input_ports[i*PACKET_BITS +: PACKET_BITS];
                else if (drain_wr && scan_ptr == PORT_BITS'(i))
                    slot[i] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (drain_wr)
            fifo_mem[wr_ptr] <= scan_pkt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            fifo_dout <= '0;
        end else begin
            if (drain_wr)
                wr_ptr <= wr_ptr + UPD_ASIZE'(1);
            if (rd_en) begin
                rd_ptr    <= rd_ptr + UPD_ASIZE'(1);
                fifo_dout <= fifo_mem[rd_ptr];
            end
            case ({drain_wr, rd_en})
                2'b10:   fifo_cnt <= fifo_cnt + (UPD_ASIZE+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (UPD_ASIZE+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            rr_ptr       <= '0;
            infl_vld     <= 1'b0;
            infl_fifo    <= 1'b0;
            infl_port    <= '0;
            skid_reg     <= '0;
            skid_vld     <= 1'b0;
            stream_out   <= '0;
            stream_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_vld)
                rr_ptr <= (grant_idx == PORT_BITS'(NUM_OUT_PORTS-1)) ? '0 : grant_idx + PORT_BITS'(1);
            infl_vld  <= rd_en | grant_vld;
            infl_fifo <= rd_en;
            infl_port <= grant_idx;
            if (skid_load) begin
                skid_reg <= infl_data;
                skid_vld <= infl_vld;
            end else if (skid_clr) begin
                skid_vld <= 1'b0;
            end
            stream_valid <= sv_nxt;
            if (so_load)
                stream_out <= so_nxt;
        end
    end

`ifdef CONVERGE_STATS_EN
    logic [31:0] pkt_cnt_q;
    always_ff @(posedge clk) begin
        if (reset)
            pkt_cnt_q <= '0;
        else if (sv_nxt)
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
    assign pkt_count = pkt_cnt_q;
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_converge_ctrl_rr.sv
// Randomized bench for converge_ctrl_rr against a queue-based behavioural model of the converger.
`timescale 1ns/1ps
module tb_converge_ctrl_rr;
    localparam int PB = 97;
    localparam int NI = 7;
    localparam int NO = 7;
    localparam int PW = 4;
    localparam int AS = 4;
    localparam int DEPTH = 1 << AS;
    localparam int NCYC = 2400;

    logic                clk = 1'b0;
    logic                reset;
    logic [NI-1:0]       freespace_update;
    logic [PB*NI-1:0]    packet_from_input_ports;
    logic [PB*NO-1:0]    packet_from_output_ports;
    logic [NO-1:0]       empty;
    logic                resend;
    logic [NO-1:0]       outport_sel;
    logic [PB-1:0]       stream_out;
    logic                stream_valid;
    logic                upd_overflow;
    logic [31:0]         pkt_count;

    converge_ctrl_rr #(
        .PACKET_BITS(PB), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO), .PORT_BITS(PW), .UPD_ASIZE(AS)
    ) dut (
        .clk(clk), .reset(reset), .freespace_update(freespace_update),
        .packet_from_input_ports(packet_from_input_ports),
        .packet_from_output_ports(packet_from_output_ports),
        .empty(empty), .resend(resend), .outport_sel(outport_sel),
        .stream_out(stream_out), .stream_valid(stream_valid),
        .upd_overflow(upd_overflow), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // behavioural model: slots, update queue, one in-flight beat, skid buffer
    bit [PB-1:0] m_slot [NI];
    bit [PB-1:0] m_q [$];
    bit [PB-1:0] m_fout, m_skid, m_so;
    bit [NI-1:0] m_fsu;
    int          m_rr, m_scan, m_fl_port;
    bit          m_fl_vld, m_fl_fifo, m_skid_vld, m_hold, m_replay, m_sv, m_ovf;
    bit [31:0]   m_cnt;

    function automatic logic [PB-1:0] rand_pkt(input bit msb);
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        t[PB-1] = msb;
        return t[PB-1:0];
    endfunction

    function automatic int exp_grant();
        if (reset || m_hold || m_replay || resend || m_q.size() != 0)
            return -1;
        for (int k = 0; k < NO; k++) begin
            int j;
            j = (m_rr + k) % NO;
            if (!empty[j])
                return j;
        end
        return -1;
    endfunction

    function automatic logic [NO-1:0] exp_sel();
        int g;
        g = exp_grant();
        if (g < 0)
            return '0;
        return NO'(1 << g);
    endfunction

    task automatic model_step();
        int g, d;
        bit rd, wr, rs;
        bit [PB-1:0] fl_data;
        bit [PB-1:0] old [NI];
        if (reset) begin
            for (int i = 0; i < NI; i++) m_slot[i] = '0;
            m_q.delete();
            m_fout = '0; m_skid = '0; m_so = '0; m_fsu = '0;
            m_rr = 0; m_scan = 0; m_fl_port = 0;
            m_fl_vld = 0; m_fl_fifo = 0; m_skid_vld = 0;
            m_hold = 0; m_replay = 0; m_sv = 0; m_ovf = 0; m_cnt = '0;
            return;
        end
        g  = exp_grant();
        rd = !m_hold && !m_replay && !resend && m_q.size() != 0;
        fl_data = m_fl_fifo ? m_fout : packet_from_output_ports[m_fl_port*PB +: PB];
        if (!m_hold && !m_replay) begin
            if (resend) begin
                m_hold = 1; m_skid = fl_data; m_skid_vld = m_fl_vld; m_sv = 0;
            end else begin
                m_sv = m_fl_vld;
                if (m_fl_vld) m_so = fl_data;
            end
        end else if (m_hold) begin
            m_sv = 0;
            if (!resend) begin m_hold = 0; m_replay = 1; end
        end else begin
            m_replay = 0;
            if (resend) begin
                m_hold = 1; m_sv = 0;
            end else begin
                m_sv = m_skid_vld;
                if (m_skid_vld) m_so = m_skid;
                m_skid_vld = 0;
            end
        end
        if (m_sv) m_cnt = m_cnt + 1;
        old = m_slot;
        d   = m_scan;
        wr  = old[d][PB-1] && (m_q.size() < DEPTH);
        if (rd) m_fout = m_q.pop_front();
        if (wr) m_q.push_back(old[d]);
        for (int i = 0; i < NI; i++) begin
            rs = freespace_update[i] && !m_fsu[i];
            if (rs) begin
                if (old[i][PB-1] && !(wr && i == d)) m_ovf = 1;
                m_slot[i] = packet_from_input_ports[i*PB +: PB];
            end else if (wr && i == d) begin
                m_slot[i] = '0;
            end
        end
        m_scan    = (d + 1) % NI;
        m_fsu     = freespace_update;
        m_fl_vld  = rd || (g >= 0);
        m_fl_fifo = rd;
        if (g >= 0) begin
            m_fl_port = g;
            m_rr      = (g + 1) % NO;
        end
    endtask

    task automatic drive(input int c);
        for (int j = 0; j < NO; j++)
            packet_from_output_ports[j*PB +: PB] = rand_pkt(1'($urandom_range(0, 1)));
        for (int i = 0; i < NI; i++)
            packet_from_input_ports[i*PB +: PB] = rand_pkt($urandom_range(0, 7) != 0);
        reset  = 1'b0;
        resend = 1'b0;
        if (c < 3) begin
            reset = 1'b1; empty = '1; freespace_update = '0;
        end else if (c < 23) begin
            empty = 7'h7E;
        end else if (c < 43) begin
            empty = 7'h55;
        end else if (c < 71) begin
            empty = NO'($urandom());
            freespace_update = ((c / 2) % 2 == 1) ? 7'h04 : 7'h00;
        end else if (c < 81) begin
            // single port-4 strobe, then a 5-cycle stall
            empty  = (c == 71) ? 7'h6F : 7'h7F;
            resend = (c >= 72 && c <= 76);
            freespace_update = '0;
        end else if (c < 141) begin
            resend = 1'b1;
            empty  = NO'($urandom());
            freespace_update = (c % 2 == 1) ? '1 : '0;
        end else if (c < 161) begin
            empty = '1; freespace_update = '0;
        end else if (c < 171) begin
            resend = 1'b1;
            empty  = NO'($urandom());
            reset  = (c == 165);
        end else begin
            empty  = NO'($urandom());
            resend = ($urandom_range(0, 9) == 0);
            reset  = ($urandom_range(0, 499) == 0);
            freespace_update = freespace_update ^
                NI'($urandom_range(0, 127) & $urandom_range(0, 127) & $urandom_range(0, 127));
        end
    endtask

    task automatic check_all();
        check_eq("outport_sel",  outport_sel,  exp_sel());
        check_eq("stream_valid", stream_valid, m_sv);
        check_eq("stream_out",   stream_out,   m_so);
        check_eq("upd_overflow", upd_overflow, m_ovf);
`ifdef CONVERGE_STATS_EN
        check_eq("pkt_count",    pkt_count,    m_cnt);
`else
        check_eq("pkt_count",    pkt_count,    32'd0);
`endif
    endtask

    initial begin
        reset = 1'b1;
        freespace_update = '0;
        packet_from_input_ports = '0;
        packet_from_output_ports = '0;
        empty = '1;
        resend = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            drive(c);
            #1;
            check_all();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
